// File: rtl/eth_pixel_scheduler.sv
// Buffers Ethernet pixel words in a show-ahead FIFO and replays them against
// free-running raster timing, resynchronising on start-of-frame after underflow.
module eth_pixel_scheduler #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int FIFO_DEPTH  = 1024,
    parameter int FILL_THRESH = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] eth_data_in,
    input  logic        eth_valid,
    input  logic        eth_sof,
    output logic        eth_ready,
    output logic [7:0]  pix_r,
    output logic [7:0]  pix_g,
    output logic [7:0]  pix_b,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        locked,
    output logic        underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int LW      = PW + 1;

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t        state;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [23:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          frame_uf;

    logic          h_last;
    logic          v_last;
    logic          frame_end;
    logic          active;
    logic          hsync_next;
    logic          vsync_next;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          pop_empty;
    logic          flush;
    logic [23:0]   head;
    logic          unused_low_byte;

    assign unused_low_byte = ^eth_data_in[7:0];

    assign h_last     = (int'(h_cnt) == H_TOTAL - 1);
    assign v_last     = (int'(v_cnt) == V_TOTAL - 1);
    assign frame_end  = h_last && v_last;
    assign active     = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    assign hsync_next = (int'(h_cnt) >= H_ACTIVE + H_FP) &&
                        (int'(h_cnt) <  H_ACTIVE + H_FP + H_SYNC);
    assign vsync_next = (int'(v_cnt) >= V_ACTIVE + V_FP) &&
                        (int'(v_cnt) <  V_ACTIVE + V_FP + V_SYNC);

    // eth_ready depends only on rst, state and level, never on eth_valid
    assign eth_ready  = !rst && ((state == IDLE) || (int'(level) < FIFO_DEPTH));
    assign fifo_empty = (level == '0);
    assign flush      = (state == RUN) && frame_end && frame_uf;
    assign push       = eth_valid && eth_ready && ((state != IDLE) || eth_sof) && !flush;
    assign pop        = (state == RUN) && active && !fifo_empty;
    assign pop_empty  = (state == RUN) && active && fifo_empty;
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= eth_data_in[31:8];
        end
    end

    // Flush on an underflowed frame drops any word arriving the same cycle
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            locked    <= 1'b0;
            frame_uf  <= 1'b0;
            de        <= 1'b0;
            hsync     <= 1'b0;
            vsync     <= 1'b0;
            underflow <= 1'b0;
            pix_r     <= 8'h00;
            pix_g     <= 8'h00;
            pix_b     <= 8'h00;
        end else begin
            de        <= active;
            hsync     <= hsync_next;
            vsync     <= vsync_next;
            underflow <= pop_empty;
            {pix_r, pix_g, pix_b} <= pop ? head : 24'h000000;
            if (pop_empty) begin
                frame_uf <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (eth_valid && eth_sof) begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (frame_end && (int'(level) >= FILL_THRESH)) begin
                        state  <= RUN;
                        locked <= 1'b1;
                    end
                end
                RUN: begin
                    if (frame_end && frame_uf) begin
                        state    <= IDLE;
                        locked   <= 1'b0;
                        frame_uf <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_pixel_scheduler.sv
// Scoreboard bench for eth_pixel_scheduler: a raster model checks timing every
// cycle, and a monitor matches each locked active pixel against a queue.
module tb_eth_pixel_scheduler;

    localparam int H_ACTIVE = 8;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 2;
    localparam int H_BP     = 2;
    localparam int V_ACTIVE = 4;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 1;
    localparam int V_BP     = 1;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOTAL * V_TOTAL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] eth_data_in = 32'h0;
    logic        eth_valid = 1'b0;
    logic        eth_sof = 1'b0;
    logic        eth_ready;
    logic [7:0]  pix_r;
    logic [7:0]  pix_g;
    logic [7:0]  pix_b;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic        locked;
    logic        underflow;

    eth_pixel_scheduler #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .FIFO_DEPTH(16), .FILL_THRESH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .eth_data_in(eth_data_in),
        .eth_valid(eth_valid),
        .eth_sof(eth_sof),
        .eth_ready(eth_ready),
        .pix_r(pix_r),
        .pix_g(pix_g),
        .pix_b(pix_b),
        .de(de),
        .hsync(hsync),
        .vsync(vsync),
        .locked(locked),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] pix;
        logic        uf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    int   m_h = 0;
    int   m_v = 0;
    logic exp_de = 1'b0;
    logic exp_hs = 1'b0;
    logic exp_vs = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected raster, one clock behind the counter position it models
    always @(posedge clk) begin
        if (rst) begin
            exp_de <= 1'b0;
            exp_hs <= 1'b0;
            exp_vs <= 1'b0;
            m_h    <= 0;
            m_v    <= 0;
        end else begin
            exp_de <= (m_h < H_ACTIVE) && (m_v < V_ACTIVE);
            exp_hs <= (m_h >= H_ACTIVE + H_FP) && (m_h < H_ACTIVE + H_FP + H_SYNC);
            exp_vs <= (m_v >= V_ACTIVE + V_FP) && (m_v < V_ACTIVE + V_FP + V_SYNC);
            if (m_h == H_TOTAL - 1) begin
                m_h <= 0;
                m_v <= (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
            end else begin
                m_h <= m_h + 1;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        checkOutput("raster", {29'd0, de, hsync, vsync}, {29'd0, exp_de, exp_hs, exp_vs});
        if (!de || !locked) begin
            checkOutput("blank_pixel", {7'd0, pix_r, pix_g, pix_b, underflow}, 32'd0);
        end else if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_pixel: got 0x%0h uf=%0b, expected no pixel at %0t",
                     {pix_r, pix_g, pix_b}, underflow, $time);
        end else begin
            e = exp_q.pop_front();
            checkOutput("pixel", {7'd0, pix_r, pix_g, pix_b, underflow}, {7'd0, e.pix, e.uf});
        end
    end

    task automatic expectWord(input logic [31:0] w);
        exp_q.push_back('{pix: w[31:8], uf: 1'b0});
    endtask

    task automatic expectUnderflow(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{pix: 24'h0, uf: 1'b1});
    endtask

    // Called at a negedge; holds the word until eth_ready, returns one negedge after acceptance
    task automatic applyStimulus(input logic [31:0] word, input logic sof);
        bit ok = 1'b0;
        eth_data_in = word;
        eth_sof     = sof;
        eth_valid   = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (eth_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        eth_valid = 1'b0;
        eth_sof   = 1'b0;
        checkOutput("send_accept", 32'(ok), 32'd1);
    endtask

    task automatic waitFramePos(input int h, input int v);
        int i = 0;
        while (!(m_h == h && m_v == v) && i < 2 * FRAME) begin
            @(negedge clk);
            i++;
        end
        if (i >= 2 * FRAME) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL frame_sync: position (%0d,%0d) not reached", h, v);
        end
    endtask

    task automatic waitLocked(input logic val, input int max_cyc, input string name);
        int i = 0;
        while (locked !== val && i < max_cyc) begin
            @(negedge clk);
            i++;
        end
        checkOutput(name, 32'(locked), 32'(val));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] w;

        // Reset held three clocks, then one full frame of raster checking
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_ready", 32'(eth_ready), 32'd0);
            checkOutput("reset_locked", 32'(locked), 32'd0);
        end
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", 32'(eth_ready), 32'd1);
        repeat (FRAME + 2) @(negedge clk);

        // Words without sof are discarded in IDLE
        for (int i = 0; i < 5; i++) applyStimulus(32'hFF000000, 1'b0);
        repeat (FRAME) @(negedge clk);
        checkOutput("idle_discard_locked", 32'(locked), 32'd0);

        // Lock-up with a full FIFO and offers refused while eth_ready is low
        waitFramePos(2, 0);
        for (int i = 0; i < 16; i++) begin
            w = (i == 0) ? 32'h00FF0000 : {8'(i), 24'h000000};
            expectWord(w);
            applyStimulus(w, (i == 0) || (i == 5));
        end
        for (int i = 0; i < 3; i++) begin
            eth_data_in = 32'hDEADBE00;
            eth_valid   = 1'b1;
            checkOutput("ready_full", 32'(eth_ready), 32'd0);
            @(negedge clk);
        end
        eth_valid = 1'b0;
        for (int i = 16; i < 32; i++) begin
            w = {8'(i), 24'h000000};
            expectWord(w);
            applyStimulus(w, 1'b0);
            if (i == 16) checkOutput("lock_after_fill", 32'(locked), 32'd1);
        end

        // Supply stops: one clean frame drains the FIFO, the next underflows
        expectUnderflow(V_ACTIVE * H_ACTIVE);
        waitLocked(1'b0, 3 * FRAME, "unlock_after_underflow");
        checkOutput("queue_drained_1", 32'(exp_q.size()), 32'd0);

        // Relock: level 7 stays below threshold, level 9 locks
        waitFramePos(2, 0);
        for (int i = 0; i < 7; i++) begin
            w = {8'h40 + 8'(i), 8'h55, 8'hAA, 8'h00};
            expectWord(w);
            applyStimulus(w, i == 0);
        end
        waitFramePos(2, 0);
        checkOutput("below_threshold", 32'(locked), 32'd0);
        for (int i = 7; i < 9; i++) begin
            w = {8'h40 + 8'(i), 8'h55, 8'hAA, 8'h00};
            expectWord(w);
            applyStimulus(w, 1'b0);
        end
        waitLocked(1'b1, 2 * FRAME, "relock");

        // Line 1 runs at level 1 with a push on every pop
        waitFramePos(0, 1);
        for (int i = 0; i < H_ACTIVE; i++) begin
            w = {8'h80 + 8'(i), 8'h11, 8'h22, 8'h00};
            eth_data_in = w;
            eth_valid   = 1'b1;
            checkOutput("ready_stream", 32'(eth_ready), 32'd1);
            expectWord(w);
            @(negedge clk);
        end
        eth_valid = 1'b0;
        expectUnderflow(2 * H_ACTIVE - 1);
        waitLocked(1'b0, 2 * FRAME, "unlock_second");
        checkOutput("queue_drained_2", 32'(exp_q.size()), 32'd0);

        // Mid-frame reset clears outputs and restarts the raster
        waitFramePos(5, 2);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset_outputs",
                    {16'd0, pix_r, pix_g, pix_b, de, hsync, vsync, locked, underflow} >> 0,
                    32'd0);
        checkOutput("midreset_ready", 32'(eth_ready), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("ready_after_midreset", 32'(eth_ready), 32'd1);
        repeat (30) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_pixel_scheduler.md
# eth_pixel_scheduler

Sits between the Ethernet pixel receive path and the TMDS encoders inside `hdmi_ethernet_top`. Buffers incoming 32-bit pixel words in an internal FIFO and generates raster timing (hsync, vsync, de). Pops one pixel per active-video clock. Aligns buffered pixels to frame start and recovers from underflow by resynchronising on the next start-of-frame word.

## Interface
Parameters:
- `H_ACTIVE`, 640: active pixels per line
- `H_FP`, 16: horizontal front porch, clocks
- `H_SYNC`, 96: hsync width, clocks
- `H_BP`, 48: horizontal back porch, clocks
- `V_ACTIVE`, 480: active lines per frame
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vsync width, lines
- `V_BP`, 33: vertical back porch, lines
- `FIFO_DEPTH`, 1024: pixel FIFO entries; power of two, ≥ 4
- `FILL_THRESH`, 512: FIFO level required before video starts; 1..FIFO_DEPTH

Ports:
- `clk`  in  1  pixel clock; single clock domain
- `rst`  in  1  synchronous reset, active-high
- `eth_data_in`  in  32  pixel word, {R[31:24], G[23:16], B[15:8], unused[7:0]}
- `eth_valid`  in  1  word valid
- `eth_sof`  in  1  qualifies `eth_data_in` as first pixel of a frame; sampled only with `eth_valid`
- `eth_ready`  out  1  word accepted when `eth_valid && eth_ready`
- `pix_r`, `pix_g`, `pix_b`  out  8 each  pixel to the TMDS encoders; 0 outside active video
- `de`, `hsync`, `vsync`  out  1 each  video timing, all active-high
- `locked`  out  1  high while in RUN
- `underflow`  out  1  one-cycle pulse per active pixel popped from an empty FIFO

## Operation
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- `h_cnt` counts 0..H_TOTAL-1 and wraps. `v_cnt` increments when `h_cnt` wraps and counts 0..V_TOTAL-1.
- Counters free-run in every state.
- Active region: `h_cnt < H_ACTIVE && v_cnt < V_ACTIVE`.
- hsync is high for `h_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- vsync is high for `v_cnt` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- `de` is high in the active region in every state. Pixel data is 0 unless a pixel is popped.
- FIFO stores 24 bits ({R,G,B}). Level is tracked 0..FIFO_DEPTH. A simultaneous push and pop leaves the level unchanged. The FIFO is show-ahead.
- State machine:
  - IDLE (reset state):
    - `eth_ready`=1.
    - Words without `eth_sof` are discarded.
    - A word with `eth_sof` is written as the first FIFO entry, then go to FILL.
  - FILL:
    - `eth_ready` = level < FIFO_DEPTH.
    - `eth_sof` is ignored; the word is written as a normal pixel.
    - Go to RUN on the last cycle of the frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1) when level ≥ FILL_THRESH at that cycle. Otherwise stay in FILL.
  - RUN:
    - `eth_ready` = level < FIFO_DEPTH.
    - Each active-region cycle pops one entry.
    - If the FIFO is empty, output pixel 0 and pulse `underflow`. Set an internal frame-underflow flag.
    - On the last cycle of the frame: if the flag is set, go to IDLE, flush the FIFO (level←0, discarding any push that cycle) and clear the flag. Otherwise stay in RUN.
- `eth_sof` is not re-checked in RUN. Upstream keeps frames contiguous.

## Timing
- Outputs are registered. `de`/`hsync`/`vsync`/`pix_*` reflect counter values from one clock earlier; latency is 1 clock.
- `eth_ready` is combinational from state and level. There is no combinational path from `eth_valid` to `eth_ready`.
- A pushed word is visible at the FIFO head the following cycle. Push-to-pixel-out latency is at least 2 clocks.
- Reset values: `eth_ready`=0 during reset and 1 on the first cycle after reset (IDLE). All other outputs are 0. Counters are 0, level is 0, state is IDLE.
- `rst` asserted mid-frame takes effect on the next edge: counters restart at 0 and FIFO contents are lost.
- `locked` asserts on the first clock of the frame that RUN begins. It deasserts on the first clock after the IDLE transition.
- `underflow` is aligned with the `de` cycle carrying the zero pixel.

## Test plan
Bench parameters: H 8/2/2/2, V 4/1/1/1 (H_TOTAL=14, V_TOTAL=7), FIFO_DEPTH=16, FILL_THRESH=8.
1. Reset check: hold `rst` 3 clocks, release. All outputs 0 during reset and `eth_ready`=1 after. First `hsync` rise is 11 clocks after release; it stays high 2 clocks. `vsync` is high for line 5 (clocks 71..84). `de` is high 8 clocks per line on lines 0..3.
2. Discard in IDLE: send 5 words 0xFF000000 without `eth_sof` → level stays 0, `locked`=0, `pix_*`=0.
3. Lock-up: send `eth_sof` with 0x00FF0000, then 31 more words with distinct R values → `locked` rises at the next frame start. The first `de` pixel is G=0xFF, followed by the subsequent words in order.
4. Backpressure: while in FILL with no pops, push 20 words → `eth_ready` falls after the 16th accept. Words offered while `eth_ready`=0 do not appear in the output stream.
5. Underflow recovery: from RUN, stop sending → `underflow` pulses once per empty active cycle with `pix_*`=0. State returns to IDLE at frame end (`locked`=0). A new `eth_sof` relocks one frame later.
6. Simultaneous push/pop at level 1 in RUN for 8 clocks → level stays 1, no `underflow`.
